// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit and memory.
// master: LSU drives req/we/addr/be/wdata; slave: memory drives ack/rdata.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: runs ALU-addressed loads/stores on a req/ack bus.
// Ports: clk, rst_n, req_* (from ALU stage), stall/ld_*/misalign/bus_err, bus (master).
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        bus_err,
    load_store_unit_if.master bus
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;

    logic        aligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] sh;
    logic [31:0] ld_ext;

    always_comb begin
        aligned = 1'b0;
        case (req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = req_wdata;
        case (req_size)
            2'b00: begin
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{req_wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = req_wdata;
            end
        endcase
    end

    // Halves are aligned, so the byte-offset shift also selects the half lane.
    always_comb begin
        sh     = bus.mem_rdata >> {off_q, 3'b000};
        ld_ext = bus.mem_rdata;
        case (size_q)
            2'b00:
                ld_ext = uns_q ? {24'b0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
            2'b01:
                ld_ext = uns_q ? {16'b0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
            default:
                ld_ext = bus.mem_rdata;
        endcase
    end

    // Accept/misalign decisions are combinational so the pipeline
    // sees the stall (or the fault) in the same cycle.
    assign stall = rst_n &
                   ((state == BUSY) |
                    ((state == IDLE) & req_valid & aligned));
    assign misalign = rst_n & (state == IDLE) & req_valid & ~aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            off_q         <= 2'b00;
            ld_valid      <= 1'b0;
            ld_data       <= 32'b0;
            bus_err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'b0;
            bus.mem_be    <= 4'b0;
            bus.mem_wdata <= 32'b0;
        end else begin
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && aligned) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= req_we;
                        bus.mem_addr  <= {req_addr[31:2], 2'b00};
                        bus.mem_be    <= be_n;
                        bus.mem_wdata <= wdata_n;
                        size_q        <= req_size;
                        uns_q         <= req_unsigned;
                        off_q         <= req_addr[1:0];
                        cnt           <= '0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        ld_data     <= bus.mem_we ? 32'b0 : ld_ext;
                        ld_valid    <= ~bus.mem_we;
                        state       <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.mem_req <= 1'b0;
                        bus_err     <= 1'b1;
                        ld_data     <= 32'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // The retiring instruction may still hold req_valid.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected bus/result
// records, a monitor pops and compares when the DUT presents them.
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign;
    logic        bus_err;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          len;
    } bus_t;

    // kind: 0 load data, 1 bus error, 2 misalign
    typedef struct {
        int          kind;
        logic [31:0] data;
    } resp_t;

    bus_t  bq[$];
    resp_t rq[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_aligned(input logic [1:0] sz,
                                     input logic [31:0] a);
        int nb;
        if (sz == 2'b11) return 1'b0;
        nb = 1 << sz;
        return (a % nb) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz,
                                        input logic [1:0] off);
        logic [3:0] be;
        int nb;
        nb = 1 << sz;
        for (int n = 0; n < 4; n++)
            be[n] = (n >= off) && (n < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz,
                                         input logic [31:0] wd);
        if (sz == 2'b00) return {24'b0, wd[7:0]} * 32'h01010101;
        if (sz == 2'b01) return {16'b0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz,
                                         input logic uns,
                                         input logic [1:0] off,
                                         input logic [31:0] rd);
        logic [63:0] m;
        logic [63:0] v;
        int nb;
        nb = 1 << sz;
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = ({32'b0, rd} >> (8 * off)) & m;
        if (!uns && nb < 4 && v > (m >> 1))
            v = v - (m + 64'd1);
        return v[31:0];
    endfunction

    // Monitor: bus-side records on mem_req rise/fall, results on pulses.
    bit    prev_req = 1'b0;
    int    run_len  = 0;
    bus_t  cur;
    initial begin
        cur = '{we: 1'b0, addr: 32'b0, be: 4'b0, wd: 32'b0, len: 0};
        forever begin
            @(negedge clk);
            #2;
            if (bus.mem_req && !prev_req) begin
                if (bq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: mem_req rose, none expected at %0t",
                             $time);
                end else begin
                    cur = bq.pop_front();
                    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_be", {28'b0, bus.mem_be}, {28'b0, cur.be});
                    if (cur.we)
                        chk("mem_wdata", bus.mem_wdata, cur.wd);
                end
                run_len = 0;
            end
            if (bus.mem_req) run_len++;
            if (!bus.mem_req && prev_req)
                chk("req_len", run_len, cur.len);
            prev_req = bus.mem_req;
            if (ld_valid || bus_err || misalign) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: ldv=%0b err=%0b mis=%0b none expected at %0t",
                             ld_valid, bus_err, misalign, $time);
                end else begin
                    resp_t r;
                    int    ak;
                    r  = rq.pop_front();
                    ak = ld_valid ? 0 : (bus_err ? 1 : 2);
                    chk("resp_kind", ak, r.kind);
                    chk("resp_single",
                        {30'b0, 2'(ld_valid + bus_err + misalign)}, 32'd1);
                    if (r.kind == 0)
                        chk("ld_data", ld_data, r.data);
                end
            end
        end
    end

    // k: ack in BUSY cycle k (1..T); 0 means never ack.
    task automatic access(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input int k,
                          input logic [31:0] rd);
        bus_t  b;
        resp_t r;
        int    sc;
        int    n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        if (!m_aligned(sz, a)) begin
            r = '{kind: 2, data: 32'b0};
            rq.push_back(r);
            #1;
            chk("mis_stall", {31'b0, stall}, 32'd0);
            chk("mis_flag", {31'b0, misalign}, 32'd1);
            @(negedge clk);
            req_valid = 1'b0;
            return;
        end
        b.we   = we;
        b.addr = {a[31:2], 2'b00};
        b.be   = m_be(sz, a[1:0]);
        b.wd   = m_wd(sz, wd);
        b.len  = (k == 0) ? T : k;
        bq.push_back(b);
        sc = 0;
        #1;
        if (stall) sc++;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            bus.mem_ack   = (n == k);
            bus.mem_rdata = (n == k) ? rd : $urandom;
            #1;
            if (stall) sc++;
            if (n == k || n == T) break;
        end
        if (k == 0) begin
            r = '{kind: 1, data: 32'b0};
            rq.push_back(r);
        end else if (!we) begin
            r = '{kind: 0, data: m_ld(sz, uns, a[1:0], rd)};
            rq.push_back(r);
        end
        @(negedge clk);
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        chk("done_stall", {31'b0, stall}, 32'd0);
        chk("stall_cycles", sc, (k == 0) ? T + 1 : k + 1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        req_valid   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_size      = 2'b00;
        req_unsigned  = 1'b0;
        req_addr      = 32'b0;
        req_wdata     = 32'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_ld_valid", {31'b0, ld_valid}, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 2, 32'h80FF1234);
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80FF1234);
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 4, 32'hABCD0000);
        access(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 2, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h0);
        access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, T, 32'h13579BDF);
        access(1'b1, 2'b00, 1'b0, 32'h45, 32'hA5, T, 32'h0);

        // Reset in the second BUSY cycle abandons the access.
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h200;
        bq.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF,
                       wd: 32'b0, len: 1});
        repeat (2) @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 2, 32'hCAFEF00D);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, T), $urandom);
        end

        repeat (5) @(negedge clk);
        chk("bus_q_empty", bq.size(), 32'd0);
        chk("resp_q_empty", rq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
